instr_sequencer: RTL

//  Instruction queue and issue sequencer in front of control_circuit. Buffers 11-bit

---
 rtl/instr_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Instruction FIFO and issue sequencer that feeds control_circuit one instruction at a time.
// Optional WAIT-state watchdog is compiled in when INSTR_SEQ_WDOG_EN is defined.
module instr_sequencer #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
`ifdef INSTR_SEQ_WDOG_EN
  ,
  parameter int unsigned WDOG_CYCLES = 8
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [10:0]       in_instr,
  output logic              in_ready,
  input  logic              run,
  input  logic              done,
  output logic [10:0]       ctrl_instr,
  output logic              busy,
  output logic [ADDR_W:0]   fifo_count,
  output logic [7:0]        retired_count,
  output logic              ctrl_reset,
  output logic              wdog_err
);

  localparam logic [2:0]        Nop     = 3'b111;
  localparam logic [ADDR_W:0]   CntFull = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CntOne  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne  = ADDR_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

  state_e            state_q;
  logic [10:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [10:0]       instr_q;
  logic [10:0]       ctrl_instr_q;
  logic              busy_q;
  logic [7:0]        retired_q;

  logic        empty;
  logic        push;
  logic        pop;
  logic [10:0] head;
  logic        head_legal;

  assign empty      = (count_q == '0);
  assign in_ready   = (count_q != CntFull);
  assign push       = in_valid & in_ready;
  assign head       = mem_q[rd_ptr_q];
  // Opcodes 1xx (including a queued NOP) are never issued.
  assign head_legal = ~head[10];

  always_comb begin
    pop = 1'b0;
    unique case (state_q)
      StIdle:  pop = ~empty & run;
      StWait:  pop = done & ~empty & run;
      default: pop = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM with registered outputs
  // ---------------------------------------------------------------------------
`ifdef INSTR_SEQ_WDOG_EN
  localparam int unsigned      WcntW    = $clog2(WDOG_CYCLES + 1);
  localparam logic [WcntW-1:0] WdogLast = WcntW'(WDOG_CYCLES - 1);
  localparam logic [WcntW-1:0] WcntOne  = WcntW'(1);

  logic [WcntW-1:0] wcnt_q;
  logic             ctrl_reset_q;
  logic             wdog_err_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      instr_q      <= {Nop, 8'h00};
      ctrl_instr_q <= {Nop, 8'h00};
      busy_q       <= 1'b0;
      retired_q    <= 8'h00;
`ifdef INSTR_SEQ_WDOG_EN
      wcnt_q       <= '0;
      ctrl_reset_q <= 1'b0;
      wdog_err_q   <= 1'b0;
`endif
    end else begin
`ifdef INSTR_SEQ_WDOG_EN
      ctrl_reset_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (pop && head_legal) begin
            instr_q      <= head;
            ctrl_instr_q <= head;
            state_q      <= StIssue;
            busy_q       <= 1'b1;
          end
        end

        StIssue: begin
          ctrl_instr_q <= {Nop, instr_q[7:0]};
          state_q      <= StWait;
`ifdef INSTR_SEQ_WDOG_EN
          wcnt_q       <= '0;
`endif
        end

        StWait: begin
          if (done) begin
            retired_q <= retired_q + 8'd1;
            if (pop && head_legal) begin
              // Back-to-back issue straight out of the done cycle.
              instr_q      <= head;
              ctrl_instr_q <= head;
              state_q      <= StIssue;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
`ifdef INSTR_SEQ_WDOG_EN
          else if (wcnt_q == WdogLast) begin
            // Give up on the instruction: kick control_circuit, drop without retiring.
            ctrl_reset_q <= 1'b1;
            wdog_err_q   <= 1'b1;
            state_q      <= StIdle;
            busy_q       <= 1'b0;
          end else begin
            wcnt_q <= wcnt_q + WcntOne;
          end
`endif
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl_instr    = ctrl_instr_q;
  assign busy          = busy_q;
  assign fifo_count    = count_q;
  assign retired_count = retired_q;

`ifdef INSTR_SEQ_WDOG_EN
  assign ctrl_reset = ctrl_reset_q;
  assign wdog_err   = wdog_err_q;
`else
  assign ctrl_reset = 1'b0;
  assign wdog_err   = 1'b0;
`endif

endmodule
